etroc1_rx: RTL

- Back-end receiver for the ETROC1 4x4 readout stream; the far end of the 30-bit parallel readout bus that the pixel readout sequencer drives toward the serializer.
- Sits after the deserializer. Parses each frame (header, pixel data words, trailer), checks frame integrity, and buffers decoded hits in a FIFO.
- Hits leave the FIFO over a valid/ready handshake to DAQ logic.

---
 rtl/etroc1_rx_if.sv | 30 +++
 rtl/etroc1_rx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/etroc1_rx_if.sv
// Hit stream between the ETROC1 receiver and the DAQ consumer.
//   hit_valid : head of the hit FIFO holds a hit
//   hit_ready : consumer accepts the head hit this cycle
//   hit_pix   : pixel index row*4+col
//   hit_bcid  : BCID of the frame that carried the hit
//   hit_tdc   : TDC payload
// master = receiver side, slave = consumer side.
interface etroc1_rx_if;
   logic        hit_valid;
   logic        hit_ready;
   logic [3:0]  hit_pix;
   logic [11:0] hit_bcid;
   logic [23:0] hit_tdc;

   modport master (
      output hit_valid,
      output hit_pix,
      output hit_bcid,
      output hit_tdc,
      input  hit_ready
   );

   modport slave (
      input  hit_valid,
      input  hit_pix,
      input  hit_bcid,
      input  hit_tdc,
      output hit_ready
   );
endinterface

// File: rtl/etroc1_rx.sv
// ETROC1 4x4 readout-stream receiver: parses header/data/trailer frames from
// the deserializer, checks frame integrity and buffers decoded hits in a FIFO.
//   clock      : system clock, rising edge
//   reset      : asynchronous, active-high
//   din        : 30-bit readout word
//   din_en     : word-valid qualifier
//   hit        : hit stream (etroc1_rx_if.master)
//   frame_done : one-cycle pulse after a good trailer
//   err_cnt    : saturating frame-error count
//   ovf_cnt    : saturating count of hits dropped on a full FIFO
module etroc1_rx #(
   parameter int unsigned FIFO_AW = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [29:0] din,
   input  logic        din_en,
   etroc1_rx_if.master hit,
   output logic        frame_done,
   output logic [7:0]  err_cnt,
   output logic [7:0]  ovf_cnt
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned CNT_W = FIFO_AW + 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
   localparam int unsigned NPIX  = 16;

   typedef struct packed {
      logic [3:0]  pix;
      logic [11:0] bcid;
      logic [23:0] tdc;
   } hit_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'b00,
      W_DATA = 2'b01,
      W_HDR  = 2'b10,
      W_TRL  = 2'b11
   } wtype_t;

   typedef enum logic {
      S_IDLE,
      S_PAYLOAD
   } state_t;

   // frame parser state
   state_t            state_q, state_d;
   logic [15:0]       roi_q, roi_d;
   logic [11:0]       bcid_q, bcid_d;
   logic [4:0]        nhit_q, nhit_d;
   logic [4:0]        ndata_q, ndata_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [3:0]        last_pix_q, last_pix_d;
   logic              have_last_q, have_last_d;
   logic              ferr_q, ferr_d;

   logic              err_inc_c;
   logic              push_c;
   logic              done_c;
   logic              start_c;
   logic              abort_c;

   // one-stage push pipeline into the FIFO
   logic              push_q;
   hit_t              push_hit_q;

   // hit FIFO
   hit_t              mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr, rd_ptr_d;
   logic [CNT_W-1:0]  count, count_d;
   logic              pop_c, full_c, wr_en_c, drop_c;
   hit_t              head_d;

   wtype_t            wtype;
   logic [3:0]        w_pix;
   logic [23:0]       w_tdc;
   logic [7:0]        w_cnt;
   logic [TMO_W-1:0]  tmo_inc;

   assign wtype   = wtype_t'(din[29:28]);
   assign w_pix   = din[27:24];
   assign w_tdc   = din[23:0];
   assign w_cnt   = din[27:20];
   assign tmo_inc = tmo_q + TMO_W'(1);

   // parser state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         roi_q       <= '0;
         bcid_q      <= '0;
         nhit_q      <= '0;
         ndata_q     <= '0;
         tmo_q       <= '0;
         last_pix_q  <= '0;
         have_last_q <= 1'b0;
         ferr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         roi_q       <= roi_d;
         bcid_q      <= bcid_d;
         nhit_q      <= nhit_d;
         ndata_q     <= ndata_d;
         tmo_q       <= tmo_d;
         last_pix_q  <= last_pix_d;
         have_last_q <= have_last_d;
         ferr_q      <= ferr_d;
      end
   end

   // parser next state; ferr_q limits error counting to once per frame
   always_comb begin
      state_d     = state_q;
      roi_d       = roi_q;
      bcid_d      = bcid_q;
      nhit_d      = nhit_q;
      ndata_d     = ndata_q;
      tmo_d       = tmo_q;
      last_pix_d  = last_pix_q;
      have_last_d = have_last_q;
      ferr_d      = ferr_q;
      err_inc_c   = 1'b0;
      push_c      = 1'b0;
      done_c      = 1'b0;
      start_c     = 1'b0;
      abort_c     = 1'b0;

      if (din_en) begin
         unique case (state_q)
            S_IDLE: begin
               case (wtype)
                  W_HDR:        start_c   = 1'b1;
                  W_DATA, W_TRL: err_inc_c = 1'b1;
                  default: ;
               endcase
            end
            S_PAYLOAD: begin
               tmo_d = tmo_inc;
               case (wtype)
                  W_HDR: begin
                     err_inc_c = !ferr_q;
                     start_c   = 1'b1;
                  end
                  W_TRL: begin
                     state_d = S_IDLE;
                     if (!ferr_q && (w_cnt == 8'(nhit_q)))
                        done_c = 1'b1;
                     else
                        err_inc_c = !ferr_q;
                  end
                  W_DATA: begin
                     if ((tmo_inc == TMO_W'(TIMEOUT)) || (ndata_q == 5'(NPIX))) begin
                        abort_c = 1'b1;
                     end else begin
                        ndata_d = ndata_q + 5'd1;
                        // in-ROI and strictly ascending pixel order
                        if (roi_q[w_pix] && (!have_last_q || (w_pix > last_pix_q))) begin
                           push_c      = 1'b1;
                           nhit_d      = nhit_q + 5'd1;
                           last_pix_d  = w_pix;
                           have_last_d = 1'b1;
                        end else begin
                           err_inc_c = !ferr_q;
                           ferr_d    = 1'b1;
                        end
                     end
                  end
                  default: begin
                     if (tmo_inc == TMO_W'(TIMEOUT))
                        abort_c = 1'b1;
                  end
               endcase
            end
         endcase
      end

      if (start_c) begin
         state_d     = S_PAYLOAD;
         roi_d       = din[27:12];
         bcid_d      = din[11:0];
         nhit_d      = '0;
         ndata_d     = '0;
         tmo_d       = '0;
         last_pix_d  = '0;
         have_last_d = 1'b0;
         ferr_d      = 1'b0;
      end

      if (abort_c) begin
         err_inc_c = !ferr_q;
         state_d   = S_IDLE;
      end
   end

   // push pipeline, frame_done pulse and saturating error count
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         push_q     <= 1'b0;
         push_hit_q <= '0;
         frame_done <= 1'b0;
         err_cnt    <= '0;
      end else begin
         push_q     <= push_c;
         frame_done <= done_c;
         if (push_c) begin
            push_hit_q.pix  <= w_pix;
            push_hit_q.bcid <= bcid_q;
            push_hit_q.tdc  <= w_tdc;
         end
         if (err_inc_c && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
      end
   end

   // FIFO control; a pop frees a slot for a same-cycle push when full
   assign pop_c   = hit.hit_valid & hit.hit_ready;
   assign full_c  = (count == CNT_W'(DEPTH));
   assign wr_en_c = push_q & (!full_c | pop_c);
   assign drop_c  = push_q & full_c & !pop_c;

   always_comb begin
      count_d  = count;
      rd_ptr_d = pop_c ? (rd_ptr + FIFO_AW'(1)) : rd_ptr;
      case ({wr_en_c, pop_c})
         2'b10:   count_d = count + CNT_W'(1);
         2'b01:   count_d = count - CNT_W'(1);
         default: count_d = count;
      endcase
      // next head; bypass the write when it lands on the new read slot
      if (count_d == '0)
         head_d = '0;
      else if (wr_en_c && (rd_ptr_d == wr_ptr))
         head_d = push_hit_q;
      else
         head_d = mem[rd_ptr_d];
   end

   // FIFO storage, no reset needed
   always_ff @(posedge clock) begin
      if (wr_en_c)
         mem[wr_ptr] <= push_hit_q;
   end

   // FIFO pointers, registered head outputs and overflow count
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         hit.hit_valid <= 1'b0;
         hit.hit_pix   <= '0;
         hit.hit_bcid  <= '0;
         hit.hit_tdc   <= '0;
         ovf_cnt       <= '0;
      end else begin
         if (wr_en_c)
            wr_ptr <= wr_ptr + FIFO_AW'(1);
         rd_ptr        <= rd_ptr_d;
         count         <= count_d;
         hit.hit_valid <= (count_d != '0);
         hit.hit_pix   <= head_d.pix;
         hit.hit_bcid  <= head_d.bcid;
         hit.hit_tdc   <= head_d.tdc;
         if (drop_c && (ovf_cnt != 8'hFF))
            ovf_cnt <= ovf_cnt + 8'd1;
      end
   end

endmodule
